// File: rtl/key_event_uart.sv
`default_nettype none
// ============================================================================
// Module      : key_event_uart
// Description : Queues 8-bit key events from the keyboard scan stage in a
//               small circular FIFO and drains them onto a UART line as
//               8N1 frames (start, 8 data bits LSB first, stop).
// Ports       : clock      - system clock, rising edge
//               reset      - synchronous, active-high
//               key_event  - event byte (bit 7 key state, 6:0 key index)
//               on_event   - push strobe, one event per cycle
//               tx         - UART line, idle high (registered)
//               busy       - high while a frame is on the line
//               fifo_count - entries queued, excluding the frame in flight
//               overflow   - sticky drop flag, cleared only by reset
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_uart #(
  parameter int BAUD_DIV = 434,
  parameter int DEPTH    = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [7:0]                 key_event,
  input  logic                       on_event,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(BAUD_DIV);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [DEPTH];

  logic baud_end;
  logic pop;
  logic push_ok;
  logic full;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    pop        = 1'b0;

    baud_end = (baud_q == BAUD_LAST);
    full     = (count_q == COUNT_MAX);

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more work is queued.
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok = on_event && (!full || pop);
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (on_event && !push_ok) begin
      overflow_d = 1'b1;
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Line level is decoded from the next state so tx leaves a flop.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= key_event;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_key_event_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_uart
// Description : Directed self-checking bench for key_event_uart with
//               BAUD_DIV=4, DEPTH=4. Expected line waveforms are built from
//               the 8N1 frame definition, one bit per clock cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_uart;

  localparam int BAUD_DIV = 4;
  localparam int DEPTH    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] key_event;
  logic       on_event;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  key_event_uart #(
    .BAUD_DIV(BAUD_DIV),
    .DEPTH   (DEPTH)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .key_event (key_event),
    .on_event  (on_event),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected tx for a 40-cycle frame; index c = cycle c after the start edge.
  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [39:0] v;
    v = '0;
    for (int c = 0; c < 40; c++) begin
      if (c < 4)       v[c] = 1'b0;
      else if (c < 36) v[c] = b[(c - 4) / 4];
      else             v[c] = 1'b1;
    end
    return v;
  endfunction

  task automatic capture(input int n, output logic [255:0] txv, output logic [255:0] bv);
    txv = '0;
    bv  = '0;
    for (int c = 0; c < n; c++) begin
      txv[c] = tx;
      bv[c]  = busy;
      step();
    end
  endtask

  function automatic logic [255:0] ones(input int n);
    logic [255:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  initial begin
    logic [255:0] obs, bsy, exp;
    int           peak;
    logic         low_seen;

    reset     = 1'b1;
    on_event  = 1'b0;
    key_event = 8'h00;
    step();
    step();
    reset = 1'b0;
    check("rst_tx", 256'(tx), 256'(1));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_count", 256'(fifo_count), 256'(0));
    check("rst_ovf", 256'(overflow), 256'(0));

    // ---- single push 0x85 ----
    on_event = 1'b1; key_event = 8'h85;
    step();
    on_event = 1'b0;
    check("t1_count_e0", 256'(fifo_count), 256'(1));
    check("t1_tx_e0", 256'(tx), 256'(1));
    step();
    check("t1_tx_e1", 256'(tx), 256'(0));
    check("t1_busy_e1", 256'(busy), 256'(1));
    check("t1_count_e1", 256'(fifo_count), 256'(0));
    capture(40, obs, bsy);
    check("t1_frame", obs, 256'(frame_bits(8'h85)));
    check("t1_busy_frame", bsy, ones(40));
    check("t1_busy_end", 256'(busy), 256'(0));
    check("t1_tx_end", 256'(tx), 256'(1));

    // ---- three back-to-back pushes ----
    obs = '0; peak = 0;
    on_event = 1'b1; key_event = 8'h01;
    step();
    key_event = 8'h02;
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
    step();
    obs[0] = tx;
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
    key_event = 8'h03;
    step();
    on_event = 1'b0;
    for (int c = 1; c < 120; c++) begin
      if (c > 1) step();
      obs[c] = tx;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    step();
    exp = '0;
    exp[39:0]   = frame_bits(8'h01);
    exp[79:40]  = frame_bits(8'h02);
    exp[119:80] = frame_bits(8'h03);
    check("t2_frames", obs, exp);
    check("t2_peak", 256'(peak), 256'(2));
    check("t2_busy_end", 256'(busy), 256'(0));

    // ---- overflow: six pushes into DEPTH=4 ----
    obs = '0;
    on_event = 1'b1; key_event = 8'h10;
    step();
    for (int i = 1; i <= 5; i++) begin
      key_event = 8'h10 + 8'(i);
      step();
      obs[i-1] = tx;
      if (i == 4) begin
        check("t3_count_e4", 256'(fifo_count), 256'(4));
        check("t3_ovf_e4", 256'(overflow), 256'(0));
      end
      if (i == 5) begin
        check("t3_ovf_e5", 256'(overflow), 256'(1));
        check("t3_count_e5", 256'(fifo_count), 256'(4));
      end
    end
    on_event = 1'b0;
    for (int c = 5; c < 200; c++) begin
      step();
      obs[c] = tx;
    end
    step();
    exp = '0;
    for (int f = 0; f < 5; f++) exp[40*f +: 40] = frame_bits(8'h10 + 8'(f));
    check("t3_frames", obs, exp);
    check("t3_busy_end", 256'(busy), 256'(0));
    low_seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (tx !== 1'b1) low_seen = 1'b1;
      step();
    end
    check("t3_no_sixth", 256'(low_seen), 256'(0));

    // ---- reset during DATA bit 3 with two entries queued ----
    on_event = 1'b1; key_event = 8'h21;
    step();
    key_event = 8'h22;
    step();
    key_event = 8'h23;
    step();
    on_event = 1'b0;
    check("t6_count", 256'(fifo_count), 256'(2));
    check("t6_ovf_sticky", 256'(overflow), 256'(1));
    repeat (16) step();
    check("t6_bit3", 256'(tx), 256'(0));
    reset = 1'b1; on_event = 1'b1; key_event = 8'hAA;
    step();
    reset = 1'b0; on_event = 1'b0;
    check("t6_tx", 256'(tx), 256'(1));
    check("t6_busy", 256'(busy), 256'(0));
    check("t6_count_rst", 256'(fifo_count), 256'(0));
    check("t6_ovf_rst", 256'(overflow), 256'(0));
    step();
    check("t6_idle_after", 256'(busy), 256'(0));
    on_event = 1'b1; key_event = 8'h5A;
    step();
    on_event = 1'b0;
    step();
    capture(40, obs, bsy);
    check("t6_frame", obs, 256'(frame_bits(8'h5A)));
    check("t6_busy_end", 256'(busy), 256'(0));

    // ---- full FIFO push coinciding with end-of-stop pop ----
    on_event = 1'b1; key_event = 8'hA0;
    step();
    for (int i = 1; i <= 4; i++) begin
      key_event = 8'hA0 + 8'(i);
      step();
    end
    on_event = 1'b0;
    check("t4_full", 256'(fifo_count), 256'(4));
    repeat (36) step();
    check("t4_count_c39", 256'(fifo_count), 256'(4));
    on_event = 1'b1; key_event = 8'hA5;
    step();
    on_event = 1'b0;
    check("t4_count_pop_push", 256'(fifo_count), 256'(4));
    check("t4_ovf", 256'(overflow), 256'(0));
    check("t4_start", 256'(tx), 256'(0));
    capture(200, obs, bsy);
    exp = '0;
    for (int f = 0; f < 5; f++) exp[40*f +: 40] = frame_bits(8'hA1 + 8'(f));
    check("t4_frames", obs, exp);
    check("t4_busy_frames", bsy, ones(200));
    check("t4_busy_end", 256'(busy), 256'(0));

    // ---- key_event toggling without strobe ----
    low_seen = 1'b0; peak = 0;
    for (int c = 0; c < 100; c++) begin
      key_event = 8'($urandom);
      step();
      if (tx !== 1'b1) low_seen = 1'b1;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    check("t5_tx_idle", 256'(low_seen), 256'(0));
    check("t5_count", 256'(peak), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_event_uart.md
# key_event_uart

Serializes key events from the keyboard scan stage onto a UART line for the host link. Each cycle `on_event` is high, the 8-bit `key_event` (bit 7 = key state, bits 6:0 = key index) is pushed into a small FIFO. A transmit FSM drains the FIFO as 8N1 frames. Sits directly downstream of `keyboard_send`; its `tx` drives the board's UART TX pin.

## Interface
- `BAUD_DIV`, 434: clock cycles per UART bit (50 MHz / 115200); legal ≥ 2.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `key_event`  in  8  event byte; sampled only when `on_event` = 1.
- `on_event`  in  1  push strobe; may be high on consecutive cycles, one event per cycle.
- `tx`  out  1  UART line, idle high.
- `busy`  out  1  high while a frame is on the line.
- `fifo_count`  out  clog2(DEPTH+1)  entries currently queued (excludes frame in flight).
- `overflow`  out  1  sticky; set when an event is dropped; cleared only by `reset`.

## Operation
- FIFO: circular buffer with read/write pointers plus count; registered outputs.
- Push on `on_event` = 1 if `fifo_count` < DEPTH, or if a pop happens in the same cycle (full + pop + push accepted, count unchanged).
- Push while full with no pop: event dropped, FIFO unchanged, `overflow` ← 1.
- `key_event` ignored when `on_event` = 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx` = 1, `busy` = 0. FIFO non-empty → pop head into shift register, go START.
  - START: `tx` = 0 for BAUD_DIV cycles → DATA.
  - DATA: 8 bits LSB first, each BAUD_DIV cycles; 3-bit bit counter → STOP after bit 7.
  - STOP: `tx` = 1 for BAUD_DIV cycles. At end: FIFO non-empty → pop, go START (no idle gap); else IDLE.
- Baud counter: counts 0..BAUD_DIV-1, reloaded on every state/bit change; no fractional correction.
- `busy` = 1 in START, DATA, STOP.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `fifo_count` = 0, `overflow` = 0, FIFO empty, FSM IDLE, counters 0.
- Push at edge E into an empty FIFO while IDLE: `fifo_count` = 1 after E. Pop at E+1, so `tx` = 0 and `busy` = 1 after E+1, and `fifo_count` returns to 0.
- Frame length exactly 10·BAUD_DIV cycles; bit k of the byte occupies cycles [(1+k)·BAUD_DIV, (2+k)·BAUD_DIV) after the start edge.
- Back-to-back frames: next start bit begins the cycle after the last stop-bit cycle.
- Reset mid-frame: `tx` = 1 after the reset edge. Frame truncated, FIFO flushed, `overflow` cleared. Push on the reset cycle is discarded.
- `overflow` sets on the edge of the dropped push.

## Test plan
- BAUD_DIV=4, single push 0x85 at E0 -> `tx` low cycles E1..E1+3, data bits 1,0,1,0,0,0,0,1 at 4 cycles each, stop high 4 cycles. `busy` falls after 40 cycles; `fifo_count` back to 0 at E1.
- BAUD_DIV=4, pushes 0x01,0x02,0x03 on three consecutive cycles -> three contiguous frames totalling 120 cycles, no idle gap, correct order. `fifo_count` peaks at 2.
- DEPTH=4, BAUD_DIV=4, pushes 0x10..0x15 on six consecutive cycles -> 0x10 popped at E1, 0x15 dropped, `overflow` = 1 after E5. Exactly five frames 0x10..0x14 are sent.
- Full FIFO (DEPTH=4) with push coinciding with end-of-stop pop -> push accepted, `fifo_count` stays 4, `overflow` stays 0.
- `key_event` toggling with `on_event` = 0 for 100 cycles -> `tx` stays 1, `fifo_count` stays 0.
- Reset asserted during DATA bit 3 with 2 entries queued -> `tx` = 1, `busy` = 0, `fifo_count` = 0, `overflow` = 0 after the edge. The next push transmits normally.
